// File: rtl/dvi_pkg.sv
// Shared DVI types: pixel/colour widths, pattern modes, bar colours.
// Used by pattern_gen and its bounce_axis helper.
package dvi_pkg;

  localparam int X_POS_W = 10;
  localparam int Y_POS_W = 10;
  localparam int COLOR_W = 8;

  localparam logic [COLOR_W-1:0] COLOR_MAX = '1;

  typedef enum logic [1:0] {
    BARS,
    CHECKER,
    GRAD,
    BOX
  } pattern_mode_t;

  typedef enum logic {
    DIR_FWD,
    DIR_BACK
  } bounce_dir_t;

  // {red, green, blue} on-flags for each of the eight bars
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    unique case (idx)
      3'd0: rgb = 3'b111;
      3'd1: rgb = 3'b110;
      3'd2: rgb = 3'b011;
      3'd3: rgb = 3'b010;
      3'd4: rgb = 3'b101;
      3'd5: rgb = 3'b100;
      3'd6: rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/pattern_gen_bounce.sv
// bounce_axis: one axis of the bouncing box.
// Steps by SPEED per step_i, clamps to the walls and reverses.
module bounce_axis
  import dvi_pkg::*;
#(
  parameter int W     = 10,
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int SPEED = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        step_i,
  output logic [W-1:0] pos_o,
  output bounce_dir_t dir_o
);

  localparam logic [W:0] HI = (W+1)'(LIMIT);

  logic [W:0]   reach;
  logic [W-1:0] pos_d;
  bounce_dir_t  dir_d;

  assign reach = {1'b0, pos_o} + (W+1)'(SIZE + SPEED);

  // next position: clamp at the far wall or at zero, else move
  always_comb begin
    pos_d = pos_o;
    dir_d = dir_o;
    if (dir_o == DIR_FWD) begin
      if (reach >= HI) begin
        pos_d = W'(LIMIT - SIZE);
        dir_d = DIR_BACK;
      end else begin
        pos_d = pos_o + W'(SPEED);
      end
    end else begin
      if (pos_o <= W'(SPEED)) begin
        pos_d = '0;
        dir_d = DIR_FWD;
      end else begin
        pos_d = pos_o - W'(SPEED);
      end
    end
  end

  // position/direction register, advanced once per frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_o <= '0;
      dir_o <= DIR_FWD;
    end else if (step_i) begin
      pos_o <= pos_d;
      dir_o <= dir_d;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: test-pattern pixel source, 1-cycle latency RGB.
// Optional border override: PATTERN_GEN_BORDER_EN.
module pattern_gen
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_SPEED = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  pattern_mode_t       mode_i,
  input  logic [X_POS_W-1:0]  x_i,
  input  logic [Y_POS_W-1:0]  y_i,
  output logic [COLOR_W-1:0]  red_o,
  output logic [COLOR_W-1:0]  green_o,
  output logic [COLOR_W-1:0]  blue_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic               frame_tick;
  logic               active;
  pattern_mode_t      mode_q;
  logic [7:0]         frame_cnt;
  logic [X_POS_W-1:0] box_x;
  logic [Y_POS_W-1:0] box_y;
  bounce_dir_t        unused_dir_x;
  bounce_dir_t        unused_dir_y;
  logic               in_box;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_on;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;

  assign frame_tick = (x_i == '0) && (y_i == '0);
  assign active = (x_i < X_POS_W'(H_ACTIVE))
               && (y_i < Y_POS_W'(V_ACTIVE));

  // per-frame state: latched mode and frame counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= BARS;
      frame_cnt <= '0;
    end else if (frame_tick) begin
      mode_q    <= mode_i;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  bounce_axis #(
    .W     (X_POS_W),
    .LIMIT (H_ACTIVE),
    .SIZE  (BOX_SIZE),
    .SPEED (BOX_SPEED)
  ) u_box_x (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .step_i (frame_tick),
    .pos_o  (box_x),
    .dir_o  (unused_dir_x)
  );

  bounce_axis #(
    .W     (Y_POS_W),
    .LIMIT (V_ACTIVE),
    .SIZE  (BOX_SIZE),
    .SPEED (BOX_SPEED)
  ) u_box_y (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .step_i (frame_tick),
    .pos_o  (box_y),
    .dir_o  (unused_dir_y)
  );

  assign in_box =
    (x_i >= box_x) &&
    ({1'b0, x_i} < {1'b0, box_x} + (X_POS_W+1)'(BOX_SIZE)) &&
    (y_i >= box_y) &&
    ({1'b0, y_i} < {1'b0, box_y} + (Y_POS_W+1)'(BOX_SIZE));

  // bar index from a chain of threshold compares
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x_i >= X_POS_W'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  assign bar_on = bar_rgb(bar_idx);

  // pattern select, optional border, then blanking
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    unique case (mode_q)
      BARS: begin
        pix_r = bar_on[2] ? COLOR_MAX : '0;
        pix_g = bar_on[1] ? COLOR_MAX : '0;
        pix_b = bar_on[0] ? COLOR_MAX : '0;
      end
      CHECKER: begin
        if (x_i[5] == y_i[5]) begin
          pix_r = COLOR_MAX;
          pix_g = COLOR_MAX;
          pix_b = COLOR_MAX;
        end
      end
      GRAD: begin
        pix_r = x_i[COLOR_W-1:0];
        pix_g = y_i[COLOR_W-1:0];
        pix_b = COLOR_W'(frame_cnt);
      end
      BOX: begin
        pix_r = in_box ? COLOR_MAX : '0;
        pix_g = in_box ? COLOR_MAX : '0;
        pix_b = COLOR_MAX;
      end
    endcase
`ifdef PATTERN_GEN_BORDER_EN
    if ((x_i == '0) || (x_i == X_POS_W'(H_ACTIVE - 1)) ||
        (y_i == '0) || (y_i == Y_POS_W'(V_ACTIVE - 1))) begin
      pix_r = COLOR_MAX;
      pix_g = COLOR_MAX;
      pix_b = COLOR_MAX;
    end
`endif
    if (!active) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  // output register: one cycle after x_i/y_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
    end else begin
      red_o   <= pix_r;
      green_o <= pix_g;
      blue_o  <= pix_b;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Testbench for pattern_gen against a frame-level reference model.
// Honours PATTERN_GEN_BORDER_EN in the same way as the design.
module tb_pattern_gen;
  import dvi_pkg::*;

  localparam int H = 640;
  localparam int V = 480;
  localparam int BS = 32;
  localparam int SPD = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  pattern_mode_t mode_i = BARS;
  logic [9:0]    x_i = 10'd700;
  logic [9:0]    y_i = 10'd500;
  logic [7:0]    red_o;
  logic [7:0]    green_o;
  logic [7:0]    blue_o;

  int errors = 0;
  int checks = 0;

  int n_ticks = 0;
  int mode_m = 0;

  logic [23:0] got;
  logic [23:0] exp;

  always #5 clk_i = ~clk_i;

  pattern_gen dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .mode_i  (mode_i),
    .x_i     (x_i),
    .y_i     (y_i),
    .red_o   (red_o),
    .green_o (green_o),
    .blue_o  (blue_o)
  );

  // box position after n frames: triangle wave between 0 and LIMIT-BS
  function automatic int tri_pos(int n, int limit);
    int span;
    int t;
    span = limit - BS;
    t = (SPD * n) % (2 * span);
    return (t <= span) ? t : (2 * span - t);
  endfunction

  function automatic logic [23:0] ref_pix(int x, int y, int mode, int n);
    logic [23:0] bars [8];
    int bx;
    int by;
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00;
    bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000;
    bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    if (x >= H || y >= V) return 24'h0;
`ifdef PATTERN_GEN_BORDER_EN
    if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return 24'hFFFFFF;
`endif
    bx = tri_pos(n, H);
    by = tri_pos(n, V);
    case (mode)
      0: return bars[x / (H / 8)];
      1: return (((x / 32) % 2) == ((y / 32) % 2)) ? 24'hFFFFFF : 24'h0;
      2: return {8'(x % 256), 8'(y % 256), 8'(n % 256)};
      default:
        return (x >= bx && x < bx + BS && y >= by && y < by + BS)
               ? 24'hFFFFFF : 24'h0000FF;
    endcase
  endfunction

  // one pixel: drive, predict, sample after the edge, update model
  task automatic step(input int x, input int y,
                      output logic [23:0] g, output logic [23:0] e);
    int m_now;
    @(negedge clk_i);
    x_i = 10'(x);
    y_i = 10'(y);
    m_now = int'(mode_i);
    e = ref_pix(x, y, mode_m, n_ticks);
    @(posedge clk_i);
    #1;
    g = {red_o, green_o, blue_o};
    x_i = 10'd700;
    y_i = 10'd500;
    if (x == 0 && y == 0) begin
      mode_m = m_now;
      n_ticks++;
    end
  endtask

  task automatic model_reset();
    n_ticks = 0;
    mode_m = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    model_reset();
    mode_i = GRAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      x_i = 10'($urandom_range(0, 799));
      y_i = 10'($urandom_range(0, 524));
      @(posedge clk_i);
      #1;
      checks++;
      if ({red_o, green_o, blue_o} !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold: got %h expected 000000",
                 {red_o, green_o, blue_o});
      end
    end
    @(negedge clk_i);
    x_i = 10'd700;
    y_i = 10'd500;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step($urandom_range(1, 639), $urandom_range(1, 479), got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_first_bars: got %h expected %h", got, exp);
      end
    end
  endtask

  task automatic test_bars();
    int xs [6];
    xs[0] = 0; xs[1] = 79; xs[2] = 80;
    xs[3] = 639; xs[4] = 640; xs[5] = 400;
    mode_i = BARS;
    step(0, 0, got, exp);
    foreach (xs[i]) begin
      step(xs[i], 100, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bars_x%0d: got %h expected %h", xs[i], got, exp);
      end
    end
  endtask

  task automatic test_mode_latch();
    mode_i = CHECKER;
    step(100, 10, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL latch_hold: got %h expected %h", got, exp);
    end
    step(200, 300, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL latch_hold2: got %h expected %h", got, exp);
    end
    step(0, 0, got, exp);
    step(32, 0, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL latch_32_0: got %h expected %h", got, exp);
    end
    step(32, 32, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL latch_32_32: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_bounce();
    int bx;
    int by;
    mode_i = BOX;
    step(0, 0, got, exp);
    for (int f = 0; f < 304; f++) begin
      bx = tri_pos(n_ticks, H);
      by = tri_pos(n_ticks, V);
      step(bx + BS - 1, by + BS - 1, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL box_in f%0d: got %h expected %h", f, got, exp);
      end
      step(bx + BS, by, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL box_right f%0d: got %h expected %h", f, got, exp);
      end
      if (bx > 0) begin
        step(bx - 1, by + 1, got, exp);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL box_left f%0d: got %h expected %h", f, got, exp);
        end
      end
      if (by > 0) begin
        step(bx + 1, by - 1, got, exp);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL box_top f%0d: got %h expected %h", f, got, exp);
        end
      end
      step(0, 0, got, exp);
    end
  endtask

  task automatic test_wrap();
    mode_i = GRAD;
    step(0, 0, got, exp);
    for (int f = 0; f < 256; f++) begin
      step(300, 20, got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL grad f%0d: got %h expected %h", f, got, exp);
      end
      step(0, 0, got, exp);
    end
  endtask

  task automatic test_border();
    int px [5];
    int py [5];
    px[0] = 0;   py[0] = 40;
    px[1] = 639; py[1] = 40;
    px[2] = 640; py[2] = 40;
    px[3] = 320; py[3] = 479;
    px[4] = 50;  py[4] = 40;
    mode_i = CHECKER;
    step(0, 0, got, exp);
    foreach (px[i]) begin
      step(px[i], py[i], got, exp);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL border_%0d_%0d: got %h expected %h",
                 px[i], py[i], got, exp);
      end
    end
  endtask

  task automatic test_random();
    int x;
    int y;
    for (int i = 0; i < 300; i++) begin
      mode_i = pattern_mode_t'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        x = 0;
        y = 0;
      end else begin
        x = $urandom_range(1, 799);
        y = $urandom_range(0, 524);
      end
      step(x, y, got, exp);
      if (!(x == 0 && y == 0)) begin
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rand_%0d_%0d: got %h expected %h", x, y, got, exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    mode_i = GRAD;
    step(0, 0, got, exp);
    step(300, 20, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_pre: got %h expected %h", got, exp);
    end
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({red_o, green_o, blue_o} !== 24'h0) begin
      errors++;
      $display("FAIL async_clear: got %h expected 000000",
               {red_o, green_o, blue_o});
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(300, 20, got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_resume: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_mode_latch();
    test_bounce();
    test_wrap();
    test_border();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
